// File: rtl/dcache_responder_if.sv
// Pipeline MEM-stage request/response signals and backing-memory handshake
// for the data cache responder; the cache itself takes the slave modport.
interface dcache_responder_if;
  logic        d_readM;
  logic        d_writeM;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_stall;
  logic        m_readM;
  logic        m_writeM;
  logic [15:0] m_address;
  logic [15:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_ack;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport slave (
    input  d_readM, d_writeM, d_address, d_wdata, m_rdata, m_ack,
    output d_rdata, d_stall, m_readM, m_writeM, m_address, m_wdata,
           hit_count, miss_count
  );

  modport master (
    output d_readM, d_writeM, d_address, d_wdata, m_rdata, m_ack,
    input  d_rdata, d_stall, m_readM, m_writeM, m_address, m_wdata,
           hit_count, miss_count
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, write-no-allocate data cache with 4-word lines.
// Define DCACHE_STATS_EN to build the saturating read hit/miss counters.
module dcache_responder #(
  parameter int INDEX_BITS = 2
) (
  input logic               Clk,
  input logic               Reset,
  dcache_responder_if.slave bus
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 16 - INDEX_BITS - 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] WDONE = 2'd3;

  logic [1:0]          state;
  logic [1:0]          nextState;
  logic [LINES-1:0]    validBits;
  logic [TAG_BITS-1:0] tagArray  [LINES];
  logic [15:0]         dataArray [LINES][4];

  logic [INDEX_BITS-1:0] reqIndex;
  logic [TAG_BITS-1:0]   reqTag;
  logic [1:0]            reqWord;
  logic                  hit;
  logic                  readHit;

  assign reqIndex = bus.d_address[INDEX_BITS+1:2];
  assign reqTag   = bus.d_address[15:INDEX_BITS+2];
  assign reqWord  = bus.d_address[1:0];
  assign hit      = validBits[reqIndex] && (tagArray[reqIndex] == reqTag);
  // A simultaneous write request masks the read, so it never counts as a hit.
  assign readHit  = (state == IDLE) && bus.d_readM && !bus.d_writeM && hit;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.d_writeM)
          nextState = WRITE;
        else if (bus.d_readM && !hit)
          nextState = FILL;
      end
      FILL:    if (bus.m_ack) nextState = IDLE;
      WRITE:   if (bus.m_ack) nextState = WDONE;
      default: nextState = IDLE;
    endcase
  end

  // The pipeline is frozen while stalled, so d_address/d_wdata stay stable
  // and can drive the memory request directly.
  always_comb begin
    bus.d_stall   = 1'b0;
    bus.d_rdata   = '0;
    bus.m_readM   = 1'b0;
    bus.m_writeM  = 1'b0;
    bus.m_address = '0;
    bus.m_wdata   = '0;
    case (state)
      IDLE: begin
        bus.d_stall = bus.d_writeM || (bus.d_readM && !hit);
        if (readHit)
          bus.d_rdata = dataArray[reqIndex][reqWord];
      end
      FILL: begin
        bus.d_stall   = 1'b1;
        bus.m_readM   = 1'b1;
        bus.m_address = {bus.d_address[15:2], 2'b00};
      end
      WRITE: begin
        bus.d_stall   = 1'b1;
        bus.m_writeM  = 1'b1;
        bus.m_address = bus.d_address;
        bus.m_wdata   = bus.d_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      validBits <= '0;
    end else begin
      state <= nextState;
      if (state == FILL && bus.m_ack)
        validBits[reqIndex] <= 1'b1;
    end
  end

  // Tags and data need no reset; they are only trusted behind a valid bit.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == FILL && bus.m_ack) begin
        tagArray[reqIndex] <= reqTag;
        for (int w = 0; w < 4; w++)
          dataArray[reqIndex][w] <= bus.m_rdata[16*w +: 16];
      end else if (state == WRITE && bus.m_ack && hit) begin
        dataArray[reqIndex][reqWord] <= bus.d_wdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [1:0]  prevState;
  logic [15:0] hitCount;
  logic [15:0] missCount;

  // The retry cycle right after a fill is the same access, so it is not a hit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prevState <= IDLE;
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      prevState <= state;
      if (state == IDLE && nextState == FILL && missCount != 16'hFFFF)
        missCount <= missCount + 16'd1;
      if (readHit && prevState != FILL && hitCount != 16'hFFFF)
        hitCount <= hitCount + 16'd1;
    end
  end

  assign bus.hit_count  = hitCount;
  assign bus.miss_count = missCount;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed cases, then random
// reads/writes checked against a memory image plus resident-tag model.
module tb_dcache_responder;

  localparam int INDEX_BITS = 2;
  localparam int LINES      = 1 << INDEX_BITS;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  dcache_responder_if bus();

  dcache_responder #(.INDEX_BITS(INDEX_BITS)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;
  int expHit      = 0;
  int expMiss     = 0;

  // Write-through keeps memory authoritative: a resident line always mirrors it.
  logic [15:0] memModel [int];
  bit          refValid [LINES];
  int          refTag   [LINES];

  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (memModel.exists(int'(a)))
      return memModel[int'(a)];
    return a ^ 16'h5A3C;
  endfunction

  function automatic int idxOf(input logic [15:0] a);
    return int'(a[INDEX_BITS+1:2]);
  endfunction

  function automatic int tagOf(input logic [15:0] a);
    return int'(a >> (INDEX_BITS + 2));
  endfunction

  function automatic logic [63:0] lineOf(input logic [15:0] a);
    logic [15:0] base;
    base = {a[15:2], 2'b00};
    return {memWord(base + 16'd3), memWord(base + 16'd2),
            memWord(base + 16'd1), memWord(base)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCounters();
`ifdef DCACHE_STATS_EN
    checkOutput("hit_count", bus.hit_count, 32'(expHit));
    checkOutput("miss_count", bus.miss_count, 32'(expMiss));
`else
    checkOutput("hit_count", bus.hit_count, 32'd0);
    checkOutput("miss_count", bus.miss_count, 32'd0);
`endif
  endtask

  task automatic clearModelOnReset();
    for (int i = 0; i < LINES; i++)
      refValid[i] = 1'b0;
    expHit  = 0;
    expMiss = 0;
  endtask

  // One pipeline access; leaves the request asserted so hits run back to back.
  task automatic applyStimulus(input bit isWrite, input logic [15:0] addr,
                               input logic [15:0] wdata, input int ackDelay);
    bit hit;
    int stallCycles;
    @(posedge Clk);
    #1;
    bus.d_readM   = !isWrite;
    bus.d_writeM  = isWrite;
    bus.d_address = addr;
    bus.d_wdata   = wdata;
    bus.m_ack     = 1'b0;
    @(negedge Clk);
    checkCounters();
    hit = refValid[idxOf(addr)] && (refTag[idxOf(addr)] == tagOf(addr));
    if (!isWrite && hit) begin
      checkOutput("hit_stall", bus.d_stall, 32'd0);
      checkOutput("hit_rdata", bus.d_rdata, 32'(memWord(addr)));
      expHit++;
    end else begin
      stallCycles = bus.d_stall ? 1 : 0;
      checkOutput("idle_mem_req", {bus.m_readM, bus.m_writeM}, 32'd0);
      for (int k = 0; k <= ackDelay; k++) begin
        @(negedge Clk);
        if (bus.d_stall) stallCycles++;
        if (isWrite) begin
          checkOutput("wr_m_readM", bus.m_readM, 32'd0);
          checkOutput("wr_m_writeM", bus.m_writeM, 32'd1);
          checkOutput("wr_m_address", bus.m_address, 32'(addr));
          checkOutput("wr_m_wdata", bus.m_wdata, 32'(wdata));
        end else begin
          checkOutput("fill_m_readM", bus.m_readM, 32'd1);
          checkOutput("fill_m_writeM", bus.m_writeM, 32'd0);
          checkOutput("fill_m_address", bus.m_address, 32'({addr[15:2], 2'b00}));
        end
        if (k == ackDelay) begin
          bus.m_ack = 1'b1;
          bus.m_rdata = isWrite ? {$urandom(), $urandom()} : lineOf(addr);
        end
      end
      @(posedge Clk);
      #1;
      bus.m_ack   = 1'b0;
      bus.m_rdata = {$urandom(), $urandom()};
      @(negedge Clk);
      checkOutput("stall_cycles", 32'(stallCycles), 32'(ackDelay + 2));
      checkOutput("stall_released", bus.d_stall, 32'd0);
      checkOutput("req_dropped", {bus.m_readM, bus.m_writeM}, 32'd0);
      if (isWrite) begin
        memModel[int'(addr)] = wdata;
      end else begin
        expMiss++;
        refValid[idxOf(addr)] = 1'b1;
        refTag[idxOf(addr)]   = tagOf(addr);
        checkOutput("fill_rdata", bus.d_rdata, 32'(memWord(addr)));
      end
    end
  endtask

  // A cycle with no request; an optional stray m_ack must be ignored.
  task automatic idleCycle(input bit strayAck);
    @(posedge Clk);
    #1;
    bus.d_readM  = 1'b0;
    bus.d_writeM = 1'b0;
    bus.m_ack    = strayAck;
    bus.m_rdata  = {$urandom(), $urandom()};
    @(negedge Clk);
    checkCounters();
    checkOutput("idle_stall", bus.d_stall, 32'd0);
    checkOutput("idle_mem_req", {bus.m_readM, bus.m_writeM}, 32'd0);
    checkOutput("idle_m_address", bus.m_address, 32'd0);
    checkOutput("idle_m_wdata", bus.m_wdata, 32'd0);
    checkOutput("idle_rdata", bus.d_rdata, 32'd0);
  endtask

  initial begin
    logic [15:0] addr;
    clearModelOnReset();
    bus.d_readM   = 1'b0;
    bus.d_writeM  = 1'b0;
    bus.d_address = '0;
    bus.d_wdata   = '0;
    bus.m_rdata   = '0;
    bus.m_ack     = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    checkOutput("rst_stall", bus.d_stall, 32'd0);
    checkOutput("rst_mem_req", {bus.m_readM, bus.m_writeM}, 32'd0);
    checkOutput("rst_m_address", bus.m_address, 32'd0);
    checkOutput("rst_m_wdata", bus.m_wdata, 32'd0);
    checkOutput("rst_rdata", bus.d_rdata, 32'd0);
    checkCounters();

    memModel[16'h0010] = 16'h0001;
    memModel[16'h0011] = 16'h0002;
    memModel[16'h0012] = 16'h0003;
    memModel[16'h0013] = 16'h0004;
    applyStimulus(1'b0, 16'h0012, 16'h0000, 2);
    applyStimulus(1'b0, 16'h0013, 16'h0000, 0);
    applyStimulus(1'b1, 16'h0011, 16'hBEEF, 1);
    applyStimulus(1'b0, 16'h0011, 16'h0000, 0);
    for (int w = 0; w < 4; w++)
      applyStimulus(1'b0, 16'h0010 + 16'(w), 16'h0000, 0);

    applyStimulus(1'b1, 16'h0100, 16'h1234, 0);
    applyStimulus(1'b0, 16'h0100, 16'h0000, 1);
    idleCycle(1'b1);

    applyStimulus(1'b0, 16'h0014, 16'h0000, 0);
    applyStimulus(1'b0, 16'h0054, 16'h0000, 1);
    applyStimulus(1'b0, 16'h0014, 16'h0000, 3);

    // Reset lands in the middle of a fill; the late m_ack must not install the line.
    @(posedge Clk);
    #1;
    bus.d_readM   = 1'b1;
    bus.d_writeM  = 1'b0;
    bus.d_address = 16'h0024;
    bus.m_ack     = 1'b0;
    @(negedge Clk);
    checkCounters();
    checkOutput("rstfill_stall", bus.d_stall, 32'd1);
    @(negedge Clk);
    checkOutput("rstfill_m_readM", bus.m_readM, 32'd1);
    Reset       = 1'b1;
    bus.d_readM = 1'b0;
    @(posedge Clk);
    #1 Reset = 1'b0;
    clearModelOnReset();
    @(negedge Clk);
    checkOutput("rstfill_req_drop", bus.m_readM, 32'd0);
    checkOutput("rstfill_stall_drop", bus.d_stall, 32'd0);
    checkCounters();
    idleCycle(1'b1);
    applyStimulus(1'b0, 16'h0024, 16'h0000, 0);
    applyStimulus(1'b0, 16'h0012, 16'h0000, 1);

    for (int n = 0; n < 300; n++) begin
      addr = 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)
        addr[15:12] = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 15) == 0)
        idleCycle(1'($urandom_range(0, 1)));
      applyStimulus(1'($urandom_range(0, 9) < 4), addr, 16'($urandom()),
                    int'($urandom_range(0, 3)));
    end
    idleCycle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
